// File: rtl/noc_axi_outstanding_tracker.sv
// Passive per-port AXI outstanding-transaction tracker: snoops AW/B/AR/R handshakes,
// keeps write/read outstanding counts and raises sticky overflow/underflow/timeout errors.
module noc_axi_outstanding_tracker #(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1),
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [NUM_PORTS-1:0]       aw_valid,
  input  logic [NUM_PORTS-1:0]       aw_ready,
  input  logic [NUM_PORTS-1:0]       b_valid,
  input  logic [NUM_PORTS-1:0]       b_ready,
  input  logic [NUM_PORTS-1:0]       ar_valid,
  input  logic [NUM_PORTS-1:0]       ar_ready,
  input  logic [NUM_PORTS-1:0]       r_valid,
  input  logic [NUM_PORTS-1:0]       r_ready,
  input  logic [NUM_PORTS-1:0]       r_last,
  output logic [NUM_PORTS*CNT_W-1:0] wr_outstanding,
  output logic [NUM_PORTS*CNT_W-1:0] rd_outstanding,
  output logic [NUM_PORTS*2-1:0]     err_overflow,
  output logic [NUM_PORTS*2-1:0]     err_underflow,
  output logic [NUM_PORTS*2-1:0]     err_timeout,
  output logic                       irq
);

  typedef enum logic [1:0] {WD_IDLE, WD_WAIT, WD_EXPIRED} wd_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TO_W-1:0]  WD_LIMIT = TO_W'(TIMEOUT_CYCLES);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // Tracker index 2p is the write direction, 2p+1 the read direction.
    for (genvar d = 0; d < 2; d++) begin : g_dir
      localparam int T = 2 * p + d;

      logic             inc, dec;
      logic             ovf_evt, unf_evt, to_evt;
      logic [CNT_W-1:0] cnt_q, cnt_nxt;
      logic [TO_W-1:0]  wd_q, wd_inc;
      logic             ovf_r, unf_r, to_r;
      wd_state_t        state_q;

      if (d == 0) begin : g_wr
        assign inc = aw_valid[p] & aw_ready[p];
        assign dec = b_valid[p] & b_ready[p];
        assign wr_outstanding[p*CNT_W +: CNT_W] = cnt_q;
      end else begin : g_rd
        assign inc = ar_valid[p] & ar_ready[p];
        assign dec = r_valid[p] & r_ready[p] & r_last[p];
        assign rd_outstanding[p*CNT_W +: CNT_W] = cnt_q;
      end

      always_comb begin
        cnt_nxt = cnt_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (inc && !dec) begin
          if (cnt_q == CNT_MAX) ovf_evt = 1'b1;
          else                  cnt_nxt = cnt_q + 1'b1;
        end else if (dec && !inc) begin
          if (cnt_q == '0) unf_evt = 1'b1;
          else             cnt_nxt = cnt_q - 1'b1;
        end
      end

      // clr restarts the watchdog, so a limit hit cannot coincide with clr.
      assign wd_inc = wd_q + 1'b1;
      assign to_evt = (state_q == WD_WAIT) && !dec && !clr && (wd_inc == WD_LIMIT);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q   <= '0;
          wd_q    <= '0;
          state_q <= WD_IDLE;
          ovf_r   <= 1'b0;
          unf_r   <= 1'b0;
          to_r    <= 1'b0;
        end else begin
          cnt_q <= cnt_nxt;
          ovf_r <= ovf_evt | (ovf_r & ~clr);
          unf_r <= unf_evt | (unf_r & ~clr);
          to_r  <= to_evt  | (to_r  & ~clr);
          case (state_q)
            WD_IDLE: begin
              wd_q <= '0;
              if (cnt_nxt != '0) state_q <= WD_WAIT;
            end
            WD_WAIT: begin
              if (cnt_nxt == '0) begin
                state_q <= WD_IDLE;
                wd_q    <= '0;
              end else if (dec || clr) begin
                wd_q <= '0;
              end else if (to_evt) begin
                state_q <= WD_EXPIRED;
                wd_q    <= wd_inc;
              end else begin
                wd_q <= wd_inc;
              end
            end
            WD_EXPIRED: begin
              if (cnt_nxt == '0) begin
                state_q <= WD_IDLE;
                wd_q    <= '0;
              end else if (dec || clr) begin
                state_q <= WD_WAIT;
                wd_q    <= '0;
              end
            end
            default: begin
              state_q <= WD_IDLE;
              wd_q    <= '0;
            end
          endcase
        end
      end

      assign err_overflow[T]  = ovf_r;
      assign err_underflow[T] = unf_r;
      assign err_timeout[T]   = to_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |{err_overflow, err_underflow, err_timeout};
  end

endmodule
